montgomery_stream_io: RTL and testbench
=======================================

# montgomery_stream_io

Word-serial front end for the 1024-bit Montgomery multiplier. It assembles operands A, B and M from a 32-bit valid/ready input stream and starts the multiplier. It then captures the result and returns it as a 32-bit valid/ready output stream. The block connects directly to the multiplier's start/in_a/in_b/in_m ports and its result/done ports. At top level the multiplier's active-low resetn is driven from ~reset.

## Interface
- DATA_W, 1024, operand/result width in bits
- WORD_W, 32, stream word width in bits; DATA_W/WORD_W = 32 words per operand
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  block accepts input word
- s_data  in  WORD_W  input word
- mont_start  out  1  one-cycle start pulse to multiplier
- mont_in_a / mont_in_b / mont_in_m  out  DATA_W  operand registers
- mont_result  in  DATA_W  multiplier result
- mont_done  in  1  multiplier completion
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts output word
- m_data  out  WORD_W  output word
- busy  out  1  high in START, WAIT, SEND

## Operation
- The FSM has six states: LOAD_A → LOAD_B → LOAD_M → START → WAIT → SEND → LOAD_A.
- A 5-bit word counter advances only on an input or output handshake. When it wraps from 31 to 0, the FSM moves to the next state.
- **Load states:**
  - s_ready=1 only in LOAD_A, LOAD_B and LOAD_M.
  - On each s_valid&&s_ready, the selected operand register shifts right by WORD_W, and s_data enters bits [DATA_W-1:DATA_W-WORD_W].
  - Words arrive least-significant first, so after 32 words word 0 sits in bits [31:0].
- **START:** mont_start=1 for exactly one cycle, then the FSM moves to WAIT.
- **WAIT:**
  - On the first cycle with mont_done=1, mont_result is copied into a DATA_W output shift register and the FSM moves to SEND.
  - mont_done is ignored in every state other than WAIT.
- **SEND:**
  - m_valid=1 and m_data = outreg[WORD_W-1:0].
  - On each m_valid&&m_ready, outreg shifts right by WORD_W.
  - After the 32nd transfer the FSM returns to LOAD_A.
- mont_in_a, mont_in_b and mont_in_m hold their values from the end of LOAD_M until each is overwritten in the next transaction.
- No arithmetic is performed. The block only concatenates and slices words; width is exact and no word is padded or dropped.

## Timing
- **Reset (synchronous):** on the next edge,
  - state=LOAD_A and counter=0;
  - all operand registers and outreg are cleared to 0;
  - s_ready=1, mont_start=0, m_valid=0, m_data=0, busy=0.
- Reset wins over every simultaneous event, including reset mid-transaction.
- **Input throughput:** one word per cycle. With s_valid held high, 96 words load in 96 cycles.
- **Start latency:** the 96th accept occurs on edge T. mont_start=1 in cycle T+1 only, and busy=1 from T+1.
- **Capture:** mont_done is sampled high on edge D. m_valid=1 from D+1, with m_data = result[31:0].
- **Output stream:**
  - While m_valid && !m_ready, m_data stays stable and m_valid stays high.
  - Once m_valid rises, it is not deasserted until the 32nd transfer. It falls in the cycle after that transfer.
  - s_ready rises in the same cycle that m_valid falls.
- s_valid asserted outside the load states has no effect.
- mont_done held high for several cycles is captured once only.

## Test plan
- **Back-to-back load.** Load A=9da0…b47e, B=325f…f325 and M=b8a2…4c47, LSW first, at one word per cycle.
  - mont_in_a/b/m must equal the full 1024-bit values.
  - mont_start must be a single pulse in the cycle after the 96th accept.
  - With the multiplier model, the 32 output words must be 0x6661aa60 first through 0x281039c3 last, reconstructing 2810…aa60.
- **Input bubbles.** Drive s_valid on alternate cycles.
  - The operands must be identical to the back-to-back case.
  - mont_start must fire exactly one cycle after the 96th handshake.
- **Output backpressure.** Hold m_ready=0 for 5 cycles after m_valid rises, then toggle it randomly.
  - m_data must stay 0x6661aa60 while stalled.
  - Exactly 32 transfers must occur, in order, with none duplicated.
- **Reset during WAIT.** Assert reset while the FSM is in WAIT.
  - On the next cycle: s_ready=1, busy=0, m_valid=0.
  - A subsequent mont_done pulse must be ignored.
  - A fresh full transaction must then pass.
- **Spurious done.** Pulse mont_done during LOAD_B, and hold it high for 4 cycles during WAIT.
  - No capture may occur in LOAD_B.
  - In WAIT there must be a single capture and exactly 32 output words.
- **Input ignored while busy.** Hold s_valid=1 throughout WAIT and SEND.
  - s_ready must stay 0 and the operand registers must stay unchanged.
  - Loading must resume only after the FSM returns to LOAD_A.

Source files
------------

// File: rtl/montgomery_stream_io.sv
// Purpose: word-serial front end for the Montgomery multiplier; assembles A, B, M from a 32-bit stream, starts the multiplier, streams the result back.
// Latency: mont_start one cycle after the 96th input accept; first result word valid one cycle after mont_done is sampled in WAIT.
// Backpressure: s_ready only in load states; output word and m_valid held stable while m_ready is low.
module montgomery_stream_io #(
    parameter int DATA_W = 1024,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              mont_start,
    output logic [DATA_W-1:0] mont_in_a,
    output logic [DATA_W-1:0] mont_in_b,
    output logic [DATA_W-1:0] mont_in_m,
    input  logic [DATA_W-1:0] mont_result,
    input  logic              mont_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              busy
);

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_M = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   word_cnt;
    logic [DATA_W-1:0]  reg_a;
    logic [DATA_W-1:0]  reg_b;
    logic [DATA_W-1:0]  reg_m;
    logic [DATA_W-1:0]  outreg;
    logic               in_hs;
    logic               out_hs;
    logic               cnt_wrap;
    logic               capture;

    assign in_hs    = s_valid && s_ready;
    assign out_hs   = m_valid && m_ready;
    assign cnt_wrap = (word_cnt == CNT_W'(NWORDS - 1));
    // mont_done only matters while waiting for the multiplier
    assign capture  = (state == WAIT) && mont_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load/send states advance when the word counter wraps
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD_A:  if (in_hs && cnt_wrap)  state_nxt = LOAD_B;
            LOAD_B:  if (in_hs && cnt_wrap)  state_nxt = LOAD_M;
            LOAD_M:  if (in_hs && cnt_wrap)  state_nxt = START;
            START:                           state_nxt = WAIT;
            WAIT:    if (mont_done)          state_nxt = SEND;
            SEND:    if (out_hs && cnt_wrap) state_nxt = LOAD_A;
            default:                         state_nxt = LOAD_A;
        endcase
    end

    // Output decode from state
    always_comb begin
        s_ready    = 1'b0;
        mont_start = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b0;
        unique case (state)
            LOAD_A, LOAD_B, LOAD_M: s_ready = 1'b1;
            START: begin
                mont_start = 1'b1;
                busy       = 1'b1;
            end
            WAIT:  busy = 1'b1;
            SEND: begin
                m_valid = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    // Word counter shared by all load and send phases; wraps 31 -> 0
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (in_hs || out_hs) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Operand shift registers: new word enters at the top, so LSW ends in [WORD_W-1:0]
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_m <= '0;
        end else if (in_hs) begin
            unique case (state)
                LOAD_A:  reg_a <= {s_data, reg_a[DATA_W-1:WORD_W]};
                LOAD_B:  reg_b <= {s_data, reg_b[DATA_W-1:WORD_W]};
                LOAD_M:  reg_m <= {s_data, reg_m[DATA_W-1:WORD_W]};
                default: ;
            endcase
        end
    end

    // Result register: captured once on leaving WAIT, then drained LSW first
    always_ff @(posedge clk) begin
        if (reset) begin
            outreg <= '0;
        end else if (capture) begin
            outreg <= mont_result;
        end else if (out_hs) begin
            outreg <= {{WORD_W{1'b0}}, outreg[DATA_W-1:WORD_W]};
        end
    end

    assign mont_in_a = reg_a;
    assign mont_in_b = reg_b;
    assign mont_in_m = reg_m;
    assign m_data    = outreg[WORD_W-1:0];

endmodule

// File: tb/tb_montgomery_stream_io.sv
// Bench for montgomery_stream_io: random operands, a behavioural multiplier stand-in,
// and word-level expectations derived from the operands the bench itself sent.
module tb_montgomery_stream_io;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic          mont_start;
    logic [1023:0] mont_in_a;
    logic [1023:0] mont_in_b;
    logic [1023:0] mont_in_m;
    logic [1023:0] mont_result;
    logic          mont_done;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    montgomery_stream_io #(.DATA_W(1024), .WORD_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .mont_start  (mont_start),
        .mont_in_a   (mont_in_a),
        .mont_in_b   (mont_in_b),
        .mont_in_m   (mont_in_m),
        .mont_result (mont_result),
        .mont_done   (mont_done),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int w;
        w = 0;
        for (int i = 31; i >= 0; i--) begin
            if (obs[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s word %0d observed=%h expected=%h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    // Stand-in multiplier function; the block is agnostic to the arithmetic
    function automatic logic [1023:0] fm(input logic [1023:0] a, input logic [1023:0] b,
                                         input logic [1023:0] m);
        return (a ^ {b[511:0], b[1023:512]}) + m;
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // mode: 0 = every cycle, 1 = alternate cycles, 2 = random gaps
    task automatic load_ops(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m,
                            input int mode, input bit spur, input bit hold_sv);
        int idx;
        int cyc;
        bit v;
        idx = 0;
        cyc = 0;
        while (idx < 96 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            chk("load_s_ready", s_ready, 1);
            if (spur) chk("spur_no_capture", m_valid, 0);
            mont_done   = spur && (idx == 40);
            mont_result = {32{32'hbad0bad0}};
            v = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = (idx < 32) ? a[idx*32 +: 32] :
                      (idx < 64) ? b[(idx-32)*32 +: 32] : m[(idx-64)*32 +: 32];
            if (v && s_ready) idx++;
        end
        if (idx < 96) chk("load_timeout", idx, 96);
        @(negedge clk);
        mont_done = 1'b0;
        s_valid   = hold_sv;
        s_data    = 32'hdeadbeef;
        chk("start_pulse", mont_start, 1);
        chk("busy_at_start", busy, 1);
        chk("s_ready_at_start", s_ready, 0);
        chk_wide("operand_a", mont_in_a, a);
        chk_wide("operand_b", mont_in_b, b);
        chk_wide("operand_m", mont_in_m, m);
        @(negedge clk);
        chk("start_single_cycle", mont_start, 0);
        chk("busy_in_wait", busy, 1);
    endtask

    // Multiplier stand-in: computes from the operand ports after some latency
    task automatic run_mult(input int lat, input bit hold_sv);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("wait_no_valid", m_valid, 0);
            if (hold_sv) chk("wait_s_ready_low", s_ready, 0);
        end
        @(negedge clk);
        mont_done   = 1'b1;
        mont_result = fm(mont_in_a, mont_in_b, mont_in_m);
    endtask

    // mode: 0 = always ready, 1 = stall 5 cycles then random ready
    task automatic recv(input logic [1023:0] er, input int mode, input int done_left, input bit hold_sv);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < 32 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done_left > 0) begin
                done_left--;
                if (cyc == 1) mont_result = ~mont_result;
            end else begin
                mont_done = 1'b0;
            end
            if (hold_sv) chk("send_s_ready_low", s_ready, 0);
            chk("m_valid_held", m_valid, 1);
            chk("m_data_word", m_data, er[k*32 +: 32]);
            m_ready = (mode == 0) ? 1'b1 : (cyc <= 5) ? 1'b0 : 1'($urandom_range(0, 1));
            if (m_valid && m_ready) k++;
        end
        if (k < 32) chk("recv_timeout", k, 32);
        @(negedge clk);
        mont_done = 1'b0;
        m_ready   = 1'b0;
        s_valid   = 1'b0;
        chk("m_valid_falls", m_valid, 0);
        chk("s_ready_rises", s_ready, 1);
        chk("busy_clears", busy, 0);
    endtask

    task automatic txn(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m,
                       input int mode_in, input int mode_out, input bit spur,
                       input int hold, input bit hold_sv, input int lat);
        logic [1023:0] er;
        er = fm(a, b, m);
        load_ops(a, b, m, mode_in, spur, hold_sv);
        run_mult(lat, hold_sv);
        recv(er, mode_out, hold - 1, hold_sv);
        if (hold_sv) begin
            chk_wide("hold_a_unchanged", mont_in_a, a);
            chk_wide("hold_b_unchanged", mont_in_b, b);
            chk_wide("hold_m_unchanged", mont_in_m, m);
        end
    endtask

    initial begin
        logic [1023:0] a, b, m;
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        mont_result = '0;
        mont_done   = 1'b0;
        m_ready     = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_mont_start", mont_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk_wide("rst_in_a", mont_in_a, '0);
        reset = 1'b0;

        a = rnd1024();
        b = rnd1024();
        m = rnd1024();
        // back-to-back load, then same operands with input bubbles
        txn(a, b, m, 0, 0, 1'b0, 1, 1'b0, 3);
        txn(a, b, m, 1, 0, 1'b0, 1, 1'b0, 2);
        // output backpressure
        txn(rnd1024(), rnd1024(), rnd1024(), 0, 1, 1'b0, 1, 1'b0, 4);

        // reset while waiting for the multiplier
        a = rnd1024();
        load_ops(a, rnd1024(), rnd1024(), 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("wrst_s_ready", s_ready, 1);
        chk("wrst_busy", busy, 0);
        chk("wrst_m_valid", m_valid, 0);
        chk("wrst_m_data", m_data, 0);
        chk_wide("wrst_in_a", mont_in_a, '0);
        mont_done   = 1'b1;
        mont_result = rnd1024();
        @(negedge clk);
        mont_done = 1'b0;
        chk("wrst_done_ignored", m_valid, 0);
        chk("wrst_still_idle", busy, 0);
        chk("wrst_s_ready_kept", s_ready, 1);
        txn(rnd1024(), rnd1024(), rnd1024(), 2, 1, 1'b0, 1, 1'b0, 1);

        // spurious done during LOAD_B and done held for 4 cycles
        txn(rnd1024(), rnd1024(), rnd1024(), 0, 0, 1'b1, 4, 1'b0, 2);
        // s_valid held through WAIT/SEND, then a normal load resumes
        txn(rnd1024(), rnd1024(), rnd1024(), 0, 1, 1'b0, 1, 1'b1, 5);
        txn(rnd1024(), rnd1024(), rnd1024(), 2, 0, 1'b0, 2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
